// File: rtl/zap_dmem_pkg.sv
// zap_dmem_pkg: shared state, width codes and defaults for the data-memory bridge.
package zap_dmem_pkg;
  localparam int ZAP_DMEM_TIMEOUT = 256;
  typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_DONE} state_t;
  typedef enum logic [2:0] {W_WORD, W_UHALF, W_SHALF, W_UBYTE, W_SBYTE} width_t;
  function automatic width_t width_of(input logic sb, input logic ub, input logic sh, input logic uh);
    return sb ? W_SBYTE : ub ? W_UBYTE : sh ? W_SHALF : uh ? W_UHALF : W_WORD;
  endfunction
  function automatic logic is_byte(input width_t w);
    return w == W_UBYTE || w == W_SBYTE;
  endfunction
  function automatic logic is_half(input width_t w);
    return w == W_UHALF || w == W_SHALF;
  endfunction
endpackage

// File: rtl/zap_dmem_load_align.sv
// zap_dmem_load_align: picks the addressed byte/halfword lane and extends it, or rotates a whole word.
module zap_dmem_load_align
  import zap_dmem_pkg::*;
(
  input  width_t      i_width,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_dat,
  output logic [31:0] o_dat
);
  logic [31:0] w_rot;
  logic [15:0] w_h;
  logic        w_sgn;
  always_comb begin
    w_rot = 32'({i_dat, i_dat} >> {i_off, 3'b000});
    w_h   = i_off[1] ? i_dat[31:16] : i_dat[15:0];
    w_sgn = i_width == W_SBYTE || i_width == W_SHALF;
    o_dat = is_byte(i_width) ? {{24{w_sgn & w_rot[7]}}, w_rot[7:0]} :
            is_half(i_width) ? {{16{w_sgn & w_h[15]}}, w_h} : w_rot;
  end
endmodule

// File: rtl/zap_dmem_bridge.sv
// zap_dmem_bridge: single-access core data port to Wishbone bridge with timeout abort.
// Define ZAP_DMEM_ALIGN_CHECK_EN to abort misaligned halfword/word-store accesses without a bus cycle.
module zap_dmem_bridge
  import zap_dmem_pkg::*;
#(
  parameter int TIMEOUT = ZAP_DMEM_TIMEOUT
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_mem_load,
  input  logic        i_mem_store,
  input  logic [31:0] i_mem_address,
  input  logic [31:0] i_mem_data,
  input  logic        i_mem_unsigned_byte_enable,
  input  logic        i_mem_signed_byte_enable,
  input  logic        i_mem_unsigned_halfword_enable,
  input  logic        i_mem_signed_halfword_enable,
  input  logic        i_force_locked_access,
  input  logic        i_freeze,
  output logic        o_data_stall,
  output logic        o_data_abort,
  output logic [31:0] o_mem_data,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic        o_wb_lock,
  output logic [3:0]  o_wb_sel,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  input  logic [31:0] i_wb_dat
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t      r_state;
  width_t      r_width;
  logic        r_store, r_lock, r_abort;
  logic [1:0]  r_off;
  logic [3:0]  r_sel;
  logic [31:0] r_adr, r_dat, r_data;
  logic [CW-1:0] r_cnt;
  width_t      w_width;
  logic        w_bus, w_idle_req, w_tmo, w_end, w_fail, w_misalign;
  logic [3:0]  w_sel;
  logic [31:0] w_rep, w_load_dat;
  always_comb begin
    w_width    = width_of(i_mem_signed_byte_enable, i_mem_unsigned_byte_enable,
                          i_mem_signed_halfword_enable, i_mem_unsigned_halfword_enable);
    w_bus      = r_state == ST_BUS;
    w_idle_req = r_state == ST_IDLE && (i_mem_load | i_mem_store) && !i_freeze;
    w_sel      = is_byte(w_width) ? 4'b0001 << i_mem_address[1:0] :
                 is_half(w_width) ? (i_mem_address[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    w_rep      = is_byte(w_width) ? {4{i_mem_data[7:0]}} :
                 is_half(w_width) ? {2{i_mem_data[15:0]}} : i_mem_data;
    w_tmo      = r_cnt == CW'(TIMEOUT - 1);
    w_end      = i_wb_ack | i_wb_err | w_tmo;
    // an ack landing on the final allowed cycle still counts as success
    w_fail     = i_wb_err | (w_tmo & ~i_wb_ack);
  end
`ifdef ZAP_DMEM_ALIGN_CHECK_EN
  assign w_misalign = (is_half(w_width) & i_mem_address[0]) |
                      (i_mem_store & ~i_mem_load & w_width == W_WORD & |i_mem_address[1:0]);
`else
  assign w_misalign = 1'b0;
`endif
  zap_dmem_load_align u_align (
    .i_width(r_width),
    .i_off  (r_off),
    .i_dat  (i_wb_dat),
    .o_dat  (w_load_dat)
  );
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_width <= W_WORD;
      r_store <= 1'b0;
      r_lock  <= 1'b0;
      r_abort <= 1'b0;
      r_off   <= '0;
      r_sel   <= '0;
      r_adr   <= '0;
      r_dat   <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else if (w_idle_req) begin
      r_state <= w_misalign ? ST_DONE : ST_BUS;
      r_width <= w_width;
      r_store <= i_mem_store & ~i_mem_load;
      r_lock  <= i_force_locked_access;
      r_abort <= w_misalign;
      r_off   <= i_mem_address[1:0];
      r_sel   <= w_sel;
      r_adr   <= {i_mem_address[31:2], 2'b00};
      r_dat   <= w_rep;
      r_data  <= '0;
      r_cnt   <= '0;
    end else if (w_bus) begin
      r_cnt <= r_cnt + CW'(1);
      if (w_end) begin
        r_state <= ST_DONE;
        r_abort <= w_fail;
        r_data  <= (w_fail | r_store) ? 32'h0 : w_load_dat;
      end
    end else if (r_state == ST_DONE) begin
      r_state <= ST_IDLE;
    end
  end
  assign o_data_stall = w_idle_req | w_bus;
  assign o_data_abort = r_state == ST_DONE && r_abort;
  assign o_mem_data   = r_data;
  assign o_wb_cyc     = w_bus;
  assign o_wb_stb     = w_bus;
  assign o_wb_we      = w_bus & r_store;
  assign o_wb_lock    = w_bus & r_lock;
  assign o_wb_sel     = r_sel;
  assign o_wb_adr     = r_adr;
  assign o_wb_dat     = r_dat;
endmodule

// File: tb/tb_zap_dmem_bridge.sv
// tb_zap_dmem_bridge: randomized and directed checks of zap_dmem_bridge against a transaction-level model.
module tb_zap_dmem_bridge;
  localparam int TO = 4;
  logic        clk = 0, i_reset = 0;
  logic        i_mem_load = 0, i_mem_store = 0, i_force_locked_access = 0, i_freeze = 0;
  logic [31:0] i_mem_address = 0, i_mem_data = 0, i_wb_dat = 0;
  logic        i_mem_unsigned_byte_enable = 0, i_mem_signed_byte_enable = 0;
  logic        i_mem_unsigned_halfword_enable = 0, i_mem_signed_halfword_enable = 0;
  logic        i_wb_ack = 0, i_wb_err = 0;
  logic        o_data_stall, o_data_abort, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_lock;
  logic [3:0]  o_wb_sel;
  logic [31:0] o_mem_data, o_wb_adr, o_wb_dat;
  int total = 0, bad = 0;

  zap_dmem_bridge #(.TIMEOUT(TO)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_mem_load(i_mem_load), .i_mem_store(i_mem_store),
    .i_mem_address(i_mem_address), .i_mem_data(i_mem_data),
    .i_mem_unsigned_byte_enable(i_mem_unsigned_byte_enable),
    .i_mem_signed_byte_enable(i_mem_signed_byte_enable),
    .i_mem_unsigned_halfword_enable(i_mem_unsigned_halfword_enable),
    .i_mem_signed_halfword_enable(i_mem_signed_halfword_enable),
    .i_force_locked_access(i_force_locked_access), .i_freeze(i_freeze),
    .o_data_stall(o_data_stall), .o_data_abort(o_data_abort), .o_mem_data(o_mem_data),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_lock(o_wb_lock),
    .o_wb_sel(o_wb_sel), .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat),
    .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .i_wb_dat(i_wb_dat)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // en = {signed byte, unsigned byte, signed half, unsigned half}; kind 0=ack 1=err 2=ack+err
  task automatic access(input logic ld, input logic st, input logic [3:0] en, input logic [31:0] addr,
                        input logic [31:0] data, input logic lk, input int delay, input int kind,
                        input logic [31:0] rdat);
    int size, shift, exp_bus, n, stall_n;
    logic sgn, is_st, fail, mis;
    logic [3:0] exp_sel;
    logic [31:0] exp_wdat, exp_load, exp_mem, v;
    size = en[3] || en[2] ? 1 : (en[1] || en[0]) ? 2 : 4;
    sgn = en[3] || (!en[2] && en[1]);
    is_st = st && !ld;
    shift = size == 1 ? int'(addr[1:0]) : size == 2 ? 2 * int'(addr[1]) : 0;
    exp_sel = 4'(((1 << size) - 1) << shift);
    for (int i = 0; i < 4; i++) exp_wdat[8*i +: 8] = 8'(data >> (8 * (i % size)));
    if (size == 4) begin
      for (int k = 0; k < 4; k++) exp_load[8*k +: 8] = 8'(rdat >> (8 * ((k + int'(addr[1:0])) % 4)));
    end else if (size == 1) begin
      v = (rdat >> (8 * addr[1:0])) & 32'hFF;
      exp_load = (sgn && v[7]) ? (v | 32'hFFFF_FF00) : v;
    end else begin
      v = (rdat >> (16 * addr[1])) & 32'hFFFF;
      exp_load = (sgn && v[15]) ? (v | 32'hFFFF_0000) : v;
    end
    mis = 0;
`ifdef ZAP_DMEM_ALIGN_CHECK_EN
    mis = (size == 2 && addr[0]) || (is_st && size == 4 && addr[1:0] != 0);
`endif
    exp_bus = mis ? 0 : (delay < TO ? delay + 1 : TO);
    fail = mis || kind != 0 || delay >= TO;
    exp_mem = (fail || is_st) ? 32'h0 : exp_load;
    i_mem_load = ld; i_mem_store = st; i_mem_address = addr; i_mem_data = data;
    {i_mem_signed_byte_enable, i_mem_unsigned_byte_enable,
     i_mem_signed_halfword_enable, i_mem_unsigned_halfword_enable} = en;
    i_force_locked_access = lk;
    #1;
    total++;
    if (o_data_stall !== 1'b1) begin bad++; $display("FAIL idle_stall: got %b want 1", o_data_stall); end
    stall_n = o_data_stall ? 1 : 0;
    @(negedge clk);
    i_mem_load = 0; i_mem_store = 0; en = 0;
    {i_mem_signed_byte_enable, i_mem_unsigned_byte_enable,
     i_mem_signed_halfword_enable, i_mem_unsigned_halfword_enable} = en;
    n = 0;
    while (o_wb_cyc === 1'b1 && n < 20) begin
      if (o_data_stall) stall_n++;
      if (n == 0) begin
        total++;
        if ({o_wb_stb, o_wb_we, o_wb_lock, o_wb_sel} !== {1'b1, is_st, lk, exp_sel}) begin
          bad++; $display("FAIL bus_ctl addr=%h: got stb/we/lock/sel %b want %b", addr,
                          {o_wb_stb, o_wb_we, o_wb_lock, o_wb_sel}, {1'b1, is_st, lk, exp_sel});
        end
        total++;
        if (o_wb_adr !== {addr[31:2], 2'b00}) begin
          bad++; $display("FAIL bus_adr: got %h want %h", o_wb_adr, {addr[31:2], 2'b00});
        end
        if (is_st) begin
          total++;
          if (o_wb_dat !== exp_wdat) begin bad++; $display("FAIL bus_dat: got %h want %h", o_wb_dat, exp_wdat); end
        end
      end
      i_wb_dat = rdat;
      i_wb_ack = n == delay && kind != 1;
      i_wb_err = n == delay && kind != 0;
      @(negedge clk);
      i_wb_ack = 0; i_wb_err = 0;
      n++;
    end
    total++;
    if (n != exp_bus) begin bad++; $display("FAIL bus_cycles addr=%h: got %0d want %0d", addr, n, exp_bus); end
    total++;
    if (stall_n != exp_bus + 1) begin bad++; $display("FAIL stall_cycles: got %0d want %0d", stall_n, exp_bus + 1); end
    total++;
    if ({o_data_stall, o_wb_cyc, o_data_abort} !== {2'b00, fail}) begin
      bad++; $display("FAIL done_flags: got stall/cyc/abort %b want %b", {o_data_stall, o_wb_cyc, o_data_abort}, {2'b00, fail});
    end
    total++;
    if (o_mem_data !== exp_mem) begin bad++; $display("FAIL mem_data addr=%h en=%b: got %h want %h", addr, en, o_mem_data, exp_mem); end
    @(negedge clk);
    total++;
    if ({o_data_abort, o_data_stall} !== 2'b00) begin
      bad++; $display("FAIL idle_after: got abort/stall %b want 00", {o_data_abort, o_data_stall});
    end
  endtask

  task automatic test_reset;
    i_reset = 1;
    #1;
    total++;
    if ({o_data_stall, o_data_abort, o_mem_data, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_lock,
         o_wb_sel, o_wb_adr, o_wb_dat} !== '0) begin
      bad++; $display("FAIL reset_outputs: got nonzero outputs sel=%b adr=%h dat=%h", o_wb_sel, o_wb_adr, o_wb_dat);
    end
    @(negedge clk); @(negedge clk);
    i_reset = 0;
    @(negedge clk);
  endtask

  task automatic test_directed;
    access(1, 0, 4'b0000, 32'h100, 0, 0, 0, 0, 32'h11223344);
    access(1, 0, 4'b1000, 32'h203, 0, 0, 0, 0, 32'h80FFFFFF);
    access(1, 0, 4'b0100, 32'h203, 0, 0, 0, 0, 32'h80FFFFFF);
    access(0, 1, 4'b0001, 32'h302, 32'h0000ABCD, 0, 1, 0, 0);
    access(1, 0, 4'b0000, 32'h301, 0, 0, 0, 0, 32'h11223344);
    access(1, 0, 4'b0000, 32'h400, 0, 0, 9, 0, 32'h55555555);
    access(1, 0, 4'b0000, 32'h404, 0, 0, 0, 2, 32'h66666666);
    access(1, 0, 4'b0010, 32'h406, 0, 1, TO - 1, 0, 32'h8001_7FFF);
    access(1, 1, 4'b1111, 32'h409, 32'hFFFF, 0, 2, 1, 32'h1234);
  endtask

  task automatic test_random;
    for (int i = 0; i < 150; i++) begin
      logic [1:0] op;
      int r;
      op = 2'($urandom_range(1, 3));
      r = $urandom_range(0, 9);
      access(op[0], op[1], 4'($urandom), $urandom, $urandom, 1'($urandom), $urandom_range(0, 5),
             r < 7 ? 0 : r < 9 ? 1 : 2, $urandom);
    end
  endtask

  task automatic test_reset_mid_bus;
    i_mem_load = 1; i_mem_address = 32'h500;
    @(negedge clk);
    i_mem_load = 0;
    total++;
    if (o_wb_cyc !== 1'b1) begin bad++; $display("FAIL mid_bus_cyc: got %b want 1", o_wb_cyc); end
    i_reset = 1;
    #1;
    total++;
    if ({o_wb_cyc, o_wb_stb, o_data_stall} !== 3'b000) begin
      bad++; $display("FAIL async_reset: got cyc/stb/stall %b want 000", {o_wb_cyc, o_wb_stb, o_data_stall});
    end
    @(negedge clk);
    i_reset = 0;
    @(negedge clk);
    access(1, 0, 4'b0000, 32'h504, 0, 0, 1, 0, 32'hCAFEF00D);
  endtask

  task automatic test_freeze;
    i_freeze = 1; i_mem_load = 1; i_mem_address = 32'h600;
    #1;
    total++;
    if (o_data_stall !== 1'b0) begin bad++; $display("FAIL freeze_stall: got %b want 0", o_data_stall); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({o_wb_cyc, o_data_stall} !== 2'b00) begin
        bad++; $display("FAIL freeze_bus: got cyc/stall %b want 00", {o_wb_cyc, o_data_stall});
      end
    end
    i_freeze = 0; i_mem_load = 0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [1:0] exp_pat [6];
    exp_pat = '{2'b10, 2'b11, 2'b00, 2'b10, 2'b11, 2'b00};
    i_mem_load = 1; i_mem_address = 32'h700; i_wb_ack = 1; i_wb_dat = 32'h0BADBEEF;
    for (int i = 0; i < 6; i++) begin
      #1;
      total++;
      if ({o_data_stall, o_wb_cyc} !== exp_pat[i]) begin
        bad++; $display("FAIL b2b_cycle%0d: got stall/cyc %b want %b", i, {o_data_stall, o_wb_cyc}, exp_pat[i]);
      end
      if (i == 2) begin
        total++;
        if (o_mem_data !== 32'h0BADBEEF) begin bad++; $display("FAIL b2b_data: got %h want 0badbeef", o_mem_data); end
      end
      if (i < 5) @(negedge clk);
    end
    i_mem_load = 0; i_wb_ack = 0;
    @(negedge clk);
  endtask

`ifdef ZAP_DMEM_ALIGN_CHECK_EN
  task automatic test_align_check;
    access(1, 0, 4'b0001, 32'h101, 0, 0, 0, 0, 32'h1);
    access(0, 1, 4'b0000, 32'h102, 32'h1, 0, 0, 0, 0);
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset;
    test_directed;
    test_random;
    test_reset_mid_bus;
    test_freeze;
    test_back_to_back;
`ifdef ZAP_DMEM_ALIGN_CHECK_EN
    test_align_check;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
